// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: request/result bundle between N_REQ requesters and the shared ALU scheduler.
interface alu_rr_scheduler_if #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 1
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [3*N_REQ-1:0] req_a;
    logic [3*N_REQ-1:0] req_b;
    logic [2*N_REQ-1:0] req_op;
    logic               res_valid;
    logic               res_ready;
    logic [3:0]         res_z;
    logic [TAG_W-1:0]   res_tag;
    logic               busy;
    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_z, res_tag, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_z, res_tag, busy
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one 3-bit ADD/SUB/AND/OR ALU, tagged valid/ready result.
module alu_rr_scheduler #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t           r_state, w_next;
    logic [TAG_W-1:0] r_last, r_tag, r_res_tag, w_win, w_idx;
    logic [2:0]       r_a, r_b;
    logic [1:0]       r_op;
    logic [3:0]       r_z, w_alu;
    logic             w_found, w_grant;
    // Search starts just after the last winner and wraps modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = TAG_W'((int'(r_last) + k) % N_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
    assign w_grant = rst_n && r_state == IDLE && w_found;
    assign bus.req_ready = w_grant ? N_REQ'(1) << w_win : '0;
    always_comb begin
        w_next = r_state == IDLE ? (w_found ? EXEC : IDLE) :
                 r_state == EXEC ? HOLD : (bus.res_ready ? IDLE : HOLD);
        w_alu = r_op == 2'b00 ? {1'b0, r_a} + {1'b0, r_b} :
                r_op == 2'b01 ? {1'b0, r_a} - {1'b0, r_b} :
                r_op == 2'b10 ? {1'b0, r_a & r_b} : {1'b0, r_a | r_b};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= TAG_W'(N_REQ - 1);
            r_tag     <= '0;
            r_res_tag <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_z       <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_a    <= bus.req_a[3*w_win +: 3];
                r_b    <= bus.req_b[3*w_win +: 3];
                r_op   <= bus.req_op[2*w_win +: 2];
                r_tag  <= w_win;
                r_last <= w_win;
            end
            if (r_state == EXEC) begin
                r_z       <= w_alu;
                r_res_tag <= r_tag;
            end
        end
    end
    assign bus.res_valid = r_state == HOLD;
    assign bus.res_z     = r_z;
    assign bus.res_tag   = r_res_tag;
    assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration, ALU results, back-pressure and async reset.
module tb_alu_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    alu_rr_scheduler_if #(.N_REQ(2), .TAG_W(1)) ifa ();
    alu_rr_scheduler_if #(.N_REQ(3), .TAG_W(2)) ifb ();
    alu_rr_scheduler #(.N_REQ(2), .TAG_W(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    alu_rr_scheduler #(.N_REQ(3), .TAG_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ifa.req_valid = 2'b11;
        ifa.req_a = '0; ifa.req_b = '0; ifa.req_op = '0; ifa.res_ready = 1'b1;
        ifb.req_valid = '0;
        ifb.req_a = '0; ifb.req_b = '0; ifb.req_op = '0; ifb.res_ready = 1'b1;
        #12;
        tests++;
        if (ifa.req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", ifa.req_ready); end
        tests++;
        if ({ifa.res_valid, ifa.busy, ifa.res_z, ifa.res_tag} !== 7'd0) begin
            fails++; $display("FAIL reset_outs got v=%b b=%b z=%h t=%h want all 0", ifa.res_valid, ifa.busy, ifa.res_z, ifa.res_tag);
        end
        ifa.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        tick;
        ifa.req_valid = 2'b01; ifa.req_a[2:0] = 3'd7; ifa.req_b[2:0] = 3'd7; ifa.req_op[1:0] = 2'b00;
        #1;
        tests++;
        if (ifa.req_ready !== 2'b01 || ifa.busy !== 1'b0) begin
            fails++; $display("FAIL add_grant got ready=%b busy=%b want 01/0", ifa.req_ready, ifa.busy);
        end
        tick;
        ifa.req_valid = 2'b00;
        tests++;
        if (ifa.busy !== 1'b1 || ifa.res_valid !== 1'b0 || ifa.req_ready !== 2'b00) begin
            fails++; $display("FAIL add_exec got busy=%b valid=%b ready=%b want 1/0/00", ifa.busy, ifa.res_valid, ifa.req_ready);
        end
        tick;
        tests++;
        if (ifa.res_valid !== 1'b1 || ifa.res_z !== 4'hE || ifa.res_tag !== 1'b0 || ifa.busy !== 1'b1) begin
            fails++; $display("FAIL add_hold got v=%b z=%h t=%h busy=%b want 1/E/0/1", ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.busy);
        end
        tick;
        tests++;
        if (ifa.busy !== 1'b0 || ifa.res_valid !== 1'b0) begin
            fails++; $display("FAIL add_idle got busy=%b valid=%b want 0/0", ifa.busy, ifa.res_valid);
        end
    endtask

    task automatic test_sub_logic;
        logic [2:0] va [4] = '{3'd1, 3'd5, 3'd5, 3'd5};
        logic [2:0] vb [4] = '{3'd2, 3'd3, 3'd3, 3'd2};
        logic [1:0] vo [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [3:0] vz [4] = '{4'hF, 4'h2, 4'h1, 4'h7};
        for (int i = 0; i < 4; i++) begin
            ifa.req_valid = 2'b10; ifa.req_a[5:3] = va[i]; ifa.req_b[5:3] = vb[i]; ifa.req_op[3:2] = vo[i];
            #1;
            tests++;
            if (ifa.req_ready !== 2'b10) begin fails++; $display("FAIL op%0d_grant got %b want 10", i, ifa.req_ready); end
            tick;
            ifa.req_valid = 2'b00;
            tick;
            tests++;
            if (ifa.res_valid !== 1'b1 || ifa.res_z !== vz[i] || ifa.res_tag !== 1'b1) begin
                fails++; $display("FAIL op%0d_result got v=%b z=%h t=%h want 1/%h/1", i, ifa.res_valid, ifa.res_z, ifa.res_tag, vz[i]);
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick;
        ifa.req_valid = 2'b11; ifa.res_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp = (g % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++;
            if (ifa.req_ready !== exp || $countones(ifa.req_ready) > 1) begin
                fails++; $display("FAIL rr_grant%0d got %b want %b", g, ifa.req_ready, exp);
            end
            tick;
            tests++;
            if (ifa.req_ready !== 2'b00) begin fails++; $display("FAIL rr_exec%0d got %b want 00", g, ifa.req_ready); end
            tick;
            tests++;
            if (ifa.req_ready !== 2'b00 || ifa.res_tag !== exp[1]) begin
                fails++; $display("FAIL rr_hold%0d got ready=%b tag=%h want 00/%h", g, ifa.req_ready, ifa.res_tag, exp[1]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        ifa.req_valid = 2'b11; ifa.req_a[2:0] = 3'd3; ifa.req_b[2:0] = 3'd4; ifa.req_op[1:0] = 2'b00;
        ifa.res_ready = 1'b0;
        #1;
        tests++;
        if (ifa.req_ready !== 2'b01) begin fails++; $display("FAIL bp_grant got %b want 01", ifa.req_ready); end
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (ifa.res_valid !== 1'b1 || ifa.res_z !== 4'h7 || ifa.res_tag !== 1'b0 || ifa.req_ready !== 2'b00 || ifa.busy !== 1'b1) begin
                fails++; $display("FAIL bp_hold%0d got v=%b z=%h t=%h ready=%b busy=%b want 1/7/0/00/1",
                                  c, ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.req_ready, ifa.busy);
            end
            tick;
        end
        ifa.res_ready = 1'b1;
        tick;
        tests++;
        if (ifa.res_valid !== 1'b0 || ifa.req_ready !== 2'b10) begin
            fails++; $display("FAIL bp_release got v=%b ready=%b want 0/10", ifa.res_valid, ifa.req_ready);
        end
        ifa.req_valid = 2'b00;
        #1;
        tests++;
        if (ifa.req_ready !== 2'b00) begin fails++; $display("FAIL bp_drop got %b want 00", ifa.req_ready); end
        tick;
        tests++;
        if (ifa.busy !== 1'b0) begin fails++; $display("FAIL bp_nogrant got busy=%b want 0", ifa.busy); end
    endtask

    task automatic test_async_reset;
        ifa.req_valid = 2'b10; ifa.req_a[5:3] = 3'd5; ifa.req_b[5:3] = 3'd2; ifa.req_op[3:2] = 2'b11;
        tick;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ifa.busy, ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.req_ready} !== 9'd0) begin
            fails++; $display("FAIL arst_exec got busy=%b v=%b z=%h t=%h ready=%b want 0", ifa.busy, ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.req_ready);
        end
        rst_n = 1'b1;
        ifa.req_valid = 2'b11; ifa.req_a[2:0] = 3'd7; ifa.req_b[2:0] = 3'd7; ifa.req_op[1:0] = 2'b00;
        ifa.res_ready = 1'b0;
        #1;
        tests++;
        if (ifa.req_ready !== 2'b01) begin fails++; $display("FAIL arst_exec_next got %b want 01", ifa.req_ready); end
        tick;
        tick;
        tests++;
        if (ifa.res_valid !== 1'b1 || ifa.res_z !== 4'hE) begin
            fails++; $display("FAIL arst_prehold got v=%b z=%h want 1/E", ifa.res_valid, ifa.res_z);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ifa.busy, ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.req_ready} !== 9'd0) begin
            fails++; $display("FAIL arst_hold got busy=%b v=%b z=%h t=%h ready=%b want 0", ifa.busy, ifa.res_valid, ifa.res_z, ifa.res_tag, ifa.req_ready);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (ifa.req_ready !== 2'b01) begin fails++; $display("FAIL arst_hold_next got %b want 01", ifa.req_ready); end
        ifa.req_valid = 2'b00; ifa.res_ready = 1'b1;
        tick;
    endtask

    task automatic test_wrap3;
        logic [2:0] vv [5] = '{3'b101, 3'b110, 3'b101, 3'b101, 3'b110};
        logic [2:0] er [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        logic [1:0] et [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            ifb.req_a[3*i +: 3] = 3'(i + 1); ifb.req_b[3*i +: 3] = 3'd1; ifb.req_op[2*i +: 2] = 2'b00;
        end
        ifb.res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            ifb.req_valid = vv[g];
            #1;
            tests++;
            if (ifb.req_ready !== er[g]) begin fails++; $display("FAIL wrap_grant%0d got %b want %b", g, ifb.req_ready, er[g]); end
            tick;
            tick;
            tests++;
            if (ifb.res_valid !== 1'b1 || ifb.res_tag !== et[g] || ifb.res_z !== 4'(et[g] + 2)) begin
                fails++; $display("FAIL wrap_res%0d got v=%b t=%h z=%h want 1/%h/%h", g, ifb.res_valid, ifb.res_tag, ifb.res_z, et[g], 4'(et[g] + 2));
            end
            tick;
        end
        ifb.req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_logic;
        test_round_robin;
        test_backpressure;
        test_async_reset;
        test_wrap3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
